// File: rtl/filter_tap_loader.sv
// Tap-set controller: stores NSETS banks of FLTLEN signed taps and streams a
// header plus the selected bank to a filter message port with GAP idle cycles.
`ifndef MSG_WIDTH
`define MSG_WIDTH 32
`endif

module filter_tap_loader #(
  parameter int WIDTH     = 32,
  parameter int FLTLEN    = 10,
  parameter int NSETS     = 4,
  parameter int GAP       = 0,
  parameter int FILTER_ID = 0,
  localparam int SW = (NSETS  > 1) ? $clog2(NSETS)  : 1,
  localparam int AW = (FLTLEN > 1) ? $clog2(FLTLEN) : 1,
  localparam int TW = WIDTH / 2,
  localparam int MW = `MSG_WIDTH
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [SW-1:0] wr_set,
  input  logic [AW-1:0] wr_addr,
  input  logic [TW-1:0] wr_data,
  input  logic          load_start,
  input  logic [SW-1:0] load_set,
  output logic          busy,
  output logic          done,
  output logic [SW-1:0] active_set,
  output logic [MW-1:0] out_msg,
  output logic          out_msg_nd,
  output logic          error
);

  typedef enum logic [1:0] {IDLE, HDR, TAP, WAIT} state_t;

  localparam logic [MW-1:0] HDR_WORD = {1'b1, (MW-1)'(FILTER_ID)};

  state_t        state;
  logic [SW-1:0] cur_set;
  logic [AW-1:0] idx;
  logic [7:0]    gap_cnt;

  // Padded to full index ranges so every index is exact-width; the entries
  // beyond NSETS/FLTLEN are never written.
  logic [TW-1:0] store [0:(1<<SW)-1][0:(1<<AW)-1];

  logic          wr_ok;
  logic          wr_bad;
  logic [AW-1:0] rd_idx;
  logic [TW-1:0] rd_tap;
  logic [MW-1:0] tap_msg;

  always_comb begin
    wr_ok  = wr_en && (32'(wr_set) < NSETS) && (32'(wr_addr) < FLTLEN)
             && !(state != IDLE && wr_set == cur_set);
    wr_bad = wr_en && !wr_ok;
    // In TAP the word being prepared is the next tap; elsewhere idx already points at it.
    rd_idx  = (state == TAP) ? idx + AW'(1) : idx;
    rd_tap  = store[cur_set][rd_idx];
    tap_msg = {1'b0, {(MW-1-TW){rd_tap[TW-1]}}, rd_tap};
  end

  always_ff @(posedge clk) begin
    if (wr_ok) store[wr_set][wr_addr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cur_set    <= '0;
      idx        <= '0;
      gap_cnt    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      active_set <= '0;
      out_msg    <= '0;
      out_msg_nd <= 1'b0;
      error      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (wr_bad || (load_start && state != IDLE)) error <= 1'b1;

      case (state)
        IDLE: begin
          out_msg    <= '0;
          out_msg_nd <= 1'b0;
          if (load_start) begin
            if (32'(load_set) < NSETS) begin
              cur_set    <= load_set;
              idx        <= '0;
              busy       <= 1'b1;
              out_msg    <= HDR_WORD;
              out_msg_nd <= 1'b1;
              state      <= HDR;
            end else begin
              error <= 1'b1;
            end
          end
        end

        HDR: begin
          if (GAP > 0) begin
            gap_cnt    <= 8'(GAP - 1);
            out_msg    <= '0;
            out_msg_nd <= 1'b0;
            state      <= WAIT;
          end else begin
            out_msg    <= tap_msg;
            out_msg_nd <= 1'b1;
            state      <= TAP;
          end
        end

        TAP: begin
          if (idx == AW'(FLTLEN - 1)) begin
            busy       <= 1'b0;
            done       <= 1'b1;
            active_set <= cur_set;
            out_msg    <= '0;
            out_msg_nd <= 1'b0;
            state      <= IDLE;
          end else begin
            idx <= idx + AW'(1);
            if (GAP > 0) begin
              gap_cnt    <= 8'(GAP - 1);
              out_msg    <= '0;
              out_msg_nd <= 1'b0;
              state      <= WAIT;
            end else begin
              out_msg    <= tap_msg;
              out_msg_nd <= 1'b1;
            end
          end
        end

        WAIT: begin
          if (gap_cnt == 8'd0) begin
            out_msg    <= tap_msg;
            out_msg_nd <= 1'b1;
            state      <= TAP;
          end else begin
            gap_cnt    <= gap_cnt - 8'd1;
            out_msg    <= '0;
            out_msg_nd <= 1'b0;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/filter_tap_loader.md
# filter_tap_loader

Tap-set controller for the FIR `filter` block. It stores `NSETS` banks of `FLTLEN` signed taps and, on command, drives the filter's message port with a header followed by the taps of the selected bank. The message pacing is programmable. It tracks which bank is live and flags protocol misuse. It sits between the control/host interface and the `in_msg`/`in_msg_nd` inputs of one filter instance.

## Interface
Parameters:
- `WIDTH`, 32: filter sample width. Taps are `WIDTH/2` bits, signed.
- `FLTLEN`, 10: number of taps per set.
- `NSETS`, 4: number of stored tap sets. Must be ≥ 1.
- `GAP`, 0: idle cycles inserted after every emitted message. Range 0–255.
- `FILTER_ID`, 0: value placed in the low bits of the header. Must fit in `` `MSG_WIDTH``−1 bits.

Ports (`SW` = max(1, ceil(log2 `NSETS`)); `AW` = max(1, ceil(log2 `FLTLEN`))):
- `clk`  in  1  sole clock; all logic is on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `wr_en`  in  1  write one tap into the store.
- `wr_set`  in  `SW`  bank index for the write.
- `wr_addr`  in  `AW`  tap index for the write.
- `wr_data`  in  `WIDTH/2`  signed tap value.
- `load_start`  in  1  single-cycle request to send a bank to the filter.
- `load_set`  in  `SW`  bank to send; sampled with `load_start`.
- `busy`  out  1  high from the cycle after acceptance until `done`.
- `done`  out  1  single-cycle pulse when a load completes.
- `active_set`  out  `SW`  bank most recently loaded in full.
- `out_msg`  out  `` `MSG_WIDTH``  message word to the filter `in_msg`.
- `out_msg_nd`  out  1  message valid, to the filter `in_msg_nd`.
- `error`  out  1  sticky error flag; cleared only by `rst`.

## Operation
- Tap store: `NSETS`×`FLTLEN` registers. The store is not cleared by `rst`, so its contents are undefined until written.
- Writes are accepted whenever `wr_set` < `NSETS`, `wr_addr` < `FLTLEN`, and the write is not to the bank currently being loaded. Otherwise the write is dropped and `error` is set.
- FSM states: IDLE, HDR, TAP, WAIT.
- IDLE:
  - `load_start` with `load_set` < `NSETS`: latch the set, clear the tap index, go to HDR.
  - `load_start` with `load_set` ≥ `NSETS`: set `error`, stay in IDLE.
- HDR: emit the header word, which is {1'b1, `FILTER_ID` zero-extended to `` `MSG_WIDTH``−1 bits}. Then go to WAIT if `GAP` > 0, else go to TAP.
- TAP: emit {1'b0, tap[idx] sign-extended to `` `MSG_WIDTH``−1 bits}.
  - If idx = `FLTLEN`−1, this is the last tap: update `active_set`, pulse `done`, return to IDLE. No trailing gap is inserted after the last tap.
  - Otherwise increment idx, then go to WAIT if `GAP` > 0, else stay in TAP.
- WAIT: count `GAP` cycles with `out_msg_nd` low, then go to TAP.
- `load_start` while `busy` is ignored and sets `error`. The load in progress is unaffected.
- `out_msg` is driven to 0 whenever `out_msg_nd` is low.

## Timing
- Reset values: `busy`=0, `done`=0, `active_set`=0, `out_msg`=0, `out_msg_nd`=0, `error`=0. The FSM resets to IDLE and the gap counter to 0.
- All outputs are registered.
- If `load_start` is accepted in cycle t:
  - header has `out_msg_nd`=1 in cycle t+1;
  - tap k appears in cycle t+1+(k+1)(`GAP`+1);
  - `done`=1 and `busy`=0 in the cycle after the last tap;
  - `busy`=1 from t+1 through the last-tap cycle.
- A new `load_start` is accepted in the same cycle `done` is high, since the FSM is already in IDLE.
- A tap write in cycle c is visible to a load whose read of that tap occurs in cycle ≥ c+1.
- Same-cycle `wr_en` and `load_start`: the write is checked against the bank being loaded only from t+1 on, so a write to `load_set` in cycle t is accepted. It is visible to that load because its first tap read is at ≥ t+1.
- `rst` mid-load: `out_msg_nd`=0 in the next cycle and the FSM returns to IDLE. The filter is left in its tap-setting state; a new load re-issues the header and recovers it, but the filter then raises its own double-header error.

## Test plan
- Write bank 1 taps 1..10, `GAP`=0, issue `load_start` with `load_set`=1 at t: header 0x80000000|`FILTER_ID` at t+1, taps 1..10 at t+2..t+11, `done` and `active_set`=1 at t+12. With a real `filter`, an impulse then outputs 1..10.
- Write tap −3 to bank 0 index 0 (`` `MSG_WIDTH``=32, `WIDTH`=32) and load bank 0: first tap word is 0x7FFFFFFD, with bit 31 equal to 0.
- `GAP`=2, load any bank: `out_msg_nd` high only at t+1, t+4, t+7, …, t+31; `done` at t+32.
- Issue `load_start` at t+3 during a load: that request is ignored, the original sequence is unchanged, and `error`=1 and remains 1 afterwards.
- Write to the bank being loaded at t+5, and separately issue `load_set`=`NSETS`: both are dropped, `error`=1, and the emitted taps equal the pre-load values.
- Assert `rst` at t+4 of a load: `out_msg_nd`=0 from t+5, `busy`=0 and `active_set`=0. A following load completes normally.
